// File: rtl/pow_5_res_fifo_pkg.sv
// Shared constants and width helpers for the pow_5 result FIFO.
//   W_DEFAULT : data width shared with the pow_5 pipeline
//   DEPTH_MIN : smallest supported FIFO depth
//   ptr_width : read/write pointer width for a given depth
//   cnt_width : occupancy counter width for a given depth (holds 0..depth)
package pow_5_res_fifo_pkg;

  localparam int W_DEFAULT = 8;
  localparam int DEPTH_MIN = 2;

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/pow_5_res_fifo_if.sv
// Handshake bundle between the pow_5 pipeline, the result FIFO and its consumer.
//   in_vld/in_data : final-stage result from the pipeline
//   pipe_en        : clock enable back to the pipeline
//   out_vld/out_data/out_rdy : consumer-side valid/ready handshake
// slave modport is the FIFO; master modport is the surrounding environment.
interface pow_5_res_fifo_if
  import pow_5_res_fifo_pkg::*;
#(
  parameter int w = W_DEFAULT
);
  logic         in_vld;
  logic [w-1:0] in_data;
  logic         pipe_en;
  logic         out_vld;
  logic [w-1:0] out_data;
  logic         out_rdy;

  modport slave (
    input  in_vld, in_data, out_rdy,
    output pipe_en, out_vld, out_data
  );

  modport master (
    output in_vld, in_data, out_rdy,
    input  pipe_en, out_vld, out_data
  );
endinterface

// File: rtl/pow_5_res_fifo_mem.sv
// depth x w storage for the result FIFO: synchronous write, asynchronous read.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write slot
//   wr_data : write data
//   rd_addr : read slot
//   rd_data : contents of rd_addr (combinational)
// Storage is intentionally not reset; the occupancy count qualifies the output.
module pow_5_res_fifo_mem
  import pow_5_res_fifo_pkg::*;
#(
  parameter int w     = W_DEFAULT,
  parameter int depth = 4,
  parameter int ptr_w = ptr_width(depth)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ptr_w-1:0] wr_addr,
  input  logic [w-1:0]     wr_data,
  input  logic [ptr_w-1:0] rd_addr,
  output logic [w-1:0]     rd_data
);

  logic [w-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pow_5_res_fifo.sv
// First-word-fall-through buffer behind the pow_5 pipeline.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   bus   : pipeline result in, pipeline clock enable out, consumer handshake out
//   count : current occupancy, 0..depth
// The pipeline only advances when a result can be captured, so consumer
// backpressure stalls the whole pipeline and no result is ever dropped.
module pow_5_res_fifo
  import pow_5_res_fifo_pkg::*;
#(
  parameter int  w     = W_DEFAULT,
  parameter int  depth = 4,
  localparam int cnt_w = cnt_width(depth)
) (
  input  logic               clk,
  input  logic               rst,
  pow_5_res_fifo_if.slave    bus,
  output logic [cnt_w-1:0]   count
);

  localparam int ptr_w = ptr_width(depth);

  if (depth < DEPTH_MIN || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("pow_5_res_fifo: depth must be a power of two and at least DEPTH_MIN");
  end

  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Enable depends on registered count only, keeping out_rdy off the
  // pipeline's enable path; a pop while full frees a slot one cycle later.
  assign bus.pipe_en = (count != cnt_w'(depth));
  assign bus.out_vld = (count != '0);

  assign push = bus.in_vld && bus.pipe_en;
  assign pop  = bus.out_vld && bus.out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
    end
  end

  pow_5_res_fifo_mem #(
    .w     (w),
    .depth (depth),
    .ptr_w (ptr_w)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr),
    .rd_data (bus.out_data)
  );

endmodule

// File: tb/tb_pow_5_res_fifo.sv
// Scoreboard bench for pow_5_res_fifo: a driver emulates the stalling pow_5
// pipeline and records each captured result; a negedge monitor checks the
// FIFO outputs and occupancy against a queue model.
module tb_pow_5_res_fifo;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count;

  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  bit  rdy_done;

  logic [7:0] exp_q[$];

  pow_5_res_fifo_if #(.w(8)) bus ();

  pow_5_res_fifo #(.w(8), .depth(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pow5(input int n);
    longint p = 1;
    for (int i = 0; i < 5; i++) p = p * n;
    return 8'(p % 256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue. Size is the occupancy, front is the head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("count_bound", 32'(count <= DEPTH), 32'd1);
      chk("pipe_en", 32'(bus.pipe_en), 32'(exp_q.size() != DEPTH));
      chk("out_vld", 32'(bus.out_vld), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        if (bus.out_rdy) void'(exp_q.pop_front());
      end
    end
  end

  // Present pipeline output for n, held until the pipeline is enabled.
  task automatic send(input int n);
    int waited = 0;
    bus.in_vld  = 1'b1;
    bus.in_data = pow5(n);
    forever begin
      @(negedge clk);
      #1;
      if (bus.pipe_en) begin
        exp_q.push_back(pow5(n));
        break;
      end
      waited++;
      if (waited > 200) begin
        errors++;
        $display("FAIL send_timeout: n=%0d never accepted", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    bus.out_rdy = 1'b1;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_pipe_en", 32'(bus.pipe_en), 32'd1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Streaming, consumer always ready.
    bus.out_rdy = 1'b1;
    send(2);
    send(3);
    send(4);
    drain();

    // Backpressure to full, then release.
    bus.out_rdy = 1'b0;
    fork
      for (int n = 1; n <= 6; n++) send(n);
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("bp_full_count", 32'(count), 32'd4);
    chk("bp_full_pipe_en", 32'(bus.pipe_en), 32'd0);
    chk("bp_head", 32'(bus.out_data), 32'd1);
    bus.out_rdy = 1'b1;
    wait fork;
    drain();

    // Full with a single-cycle pop while the next result is held.
    bus.out_rdy = 1'b0;
    fork
      for (int n = 7; n <= 11; n++) send(n);
    join_none
    repeat (10) @(posedge clk);
    #1;
    chk("fp_full_count", 32'(count), 32'd4);
    bus.out_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b0;
    chk("fp_after_pop", 32'(count), 32'd3);
    @(posedge clk);
    #1;
    chk("fp_refill", 32'(count), 32'd4);
    chk("fp_head", 32'(bus.out_data), 32'(pow5(8)));
    wait fork;
    drain();

    // Single push into empty with consumer ready.
    bus.out_rdy = 1'b1;
    send(3);
    chk("single_vld", 32'(bus.out_vld), 32'd1);
    chk("single_data", 32'(bus.out_data), 32'd243);
    @(posedge clk);
    #1;
    chk("single_gone", 32'(count), 32'd0);

    // Pointer wrap with random consumer readiness.
    rdy_done = 1'b0;
    fork
      begin
        while (!rdy_done) begin
          bus.out_rdy = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join_none
    for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 255)));
    rdy_done = 1'b1;
    wait fork;
    drain();

    // Asynchronous reset with three entries buffered.
    bus.out_rdy = 1'b0;
    send(5);
    send(6);
    send(7);
    chk("pre_rst_count", 32'(count), 32'd3);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_pipe_en", 32'(bus.pipe_en), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    bus.out_rdy = 1'b1;
    send(2);
    chk("post_rst_data", 32'(bus.out_data), 32'd32);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
